// File: rtl/noc_pkg.sv
// Shared NoC definitions: output-port (gate) codes, requester source codes,
// handshake encodings and the route-request FSM state type.
package noc_pkg;

  // Output-port codes driven on gate
  localparam logic [2:0] GATE_IP    = 3'd0;
  localparam logic [2:0] GATE_NORTH = 3'd1;
  localparam logic [2:0] GATE_SOUTH = 3'd2;
  localparam logic [2:0] GATE_EAST  = 3'd3;
  localparam logic [2:0] GATE_WEST  = 3'd4;
  localparam logic [2:0] GATE_NONE  = 3'd7;

  // Requester source codes driven on source
  localparam logic [3:0] SRC_IP    = 4'd0;
  localparam logic [3:0] SRC_NORTH = 4'd1;
  localparam logic [3:0] SRC_SOUTH = 4'd2;
  localparam logic [3:0] SRC_EAST  = 4'd3;
  localparam logic [3:0] SRC_WEST  = 4'd4;
  localparam logic [3:0] SRC_NONE  = 4'hf;

  // Handshake phase codes driven on handshake_check
  localparam logic [1:0] HS_IDLE     = 2'b00;
  localparam logic [1:0] HS_REQUEST  = 2'b01;
  localparam logic [1:0] HS_TRANSFER = 2'b10;
  localparam logic [1:0] HS_RELEASE  = 2'b11;

  // Route-request FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_REQ,
    ST_BACKOFF,
    ST_XFER,
    ST_RELEASE
  } state_e;

  // A zero-length header still carries one payload flit
  function automatic logic [3:0] eff_len(input logic [3:0] len);
    return (len == '0) ? 4'd1 : len;
  endfunction

  // Handshake phase shown for each FSM state
  function automatic logic [1:0] hs_of_state(input state_e st);
    case (st)
      ST_REQ:     return HS_REQUEST;
      ST_XFER:    return HS_TRANSFER;
      ST_RELEASE: return HS_RELEASE;
      default:    return HS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/route_request_xy_route.sv
// Combinational dimension-ordered (X then Y) route computation for a 3x3 mesh.
// Coordinate 3 does not exist in the mesh and flags the header as unroutable.
module xy_route
  import noc_pkg::*;
#(
  parameter int unsigned LOC_X = 1,
  parameter int unsigned LOC_Y = 1
) (
  input  logic [3:0] dest,
  output logic [2:0] gate,
  output logic       invalid
);

  localparam logic [1:0] LX = LOC_X[1:0];
  localparam logic [1:0] LY = LOC_Y[1:0];

  logic [1:0] dest_x;
  logic [1:0] dest_y;

  assign dest_x = dest[1:0];
  assign dest_y = dest[3:2];

  // Resolve X first, then Y; an out-of-mesh coordinate overrides any route
  always_comb begin
    gate    = GATE_NONE;
    invalid = 1'b0;
    if (dest_x == 2'd3 || dest_y == 2'd3) begin
      invalid = 1'b1;
    end else if (dest_x > LX) begin
      gate = GATE_EAST;
    end else if (dest_x < LX) begin
      gate = GATE_WEST;
    end else if (dest_y > LY) begin
      gate = GATE_SOUTH;
    end else if (dest_y < LY) begin
      gate = GATE_NORTH;
    end else begin
      gate = GATE_IP;
    end
  end

endmodule

// File: rtl/route_request.sv
// Input-port route requester: accepts a packet header, XY-routes it, requests
// the chosen output port from the crossbar, streams the payload flits while
// granted and releases the port afterwards. Unanswered requests back off
// for one cycle every TIMEOUT cycles.
module route_request
  import noc_pkg::*;
#(
  parameter int unsigned LOC_X   = 1,
  parameter int unsigned LOC_Y   = 1,
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       hdr_valid,
  input  logic [3:0] hdr_dest,
  input  logic [3:0] hdr_len,
  output logic       hdr_ready,
  input  logic       flit_valid,
  output logic       flit_ready,
  input  logic       grant,
  output logic [1:0] handshake_check,
  output logic [3:0] source,
  output logic [2:0] gate,
  output logic       busy,
  output logic       err
);

  localparam logic [3:0] SRC_ID    = PORT_ID[3:0];
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] dest_q,  dest_d;
  logic [3:0] len_q,   len_d;
  logic [2:0] gate_q,  gate_d;
  logic [3:0] wait_q,  wait_d;
  logic [3:0] beat_q,  beat_d;
  logic       err_q,   err_d;

  logic [2:0] route_gate;
  logic       route_invalid;
  logic       flit_xfer;

  xy_route #(
    .LOC_X (LOC_X),
    .LOC_Y (LOC_Y)
  ) u_xy_route (
    .dest    (dest_q),
    .gate    (route_gate),
    .invalid (route_invalid)
  );

  assign flit_xfer = flit_valid && grant;

  // Next-state and datapath updates; with enable low everything holds
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    len_d   = len_q;
    gate_d  = gate_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    err_d   = err_q;
    if (enable) begin
      err_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hdr_valid) begin
            dest_d  = hdr_dest;
            len_d   = hdr_len;
            state_d = ST_ROUTE;
          end
        end
        ST_ROUTE: begin
          if (route_invalid) begin
            err_d   = 1'b1;
            gate_d  = GATE_NONE;
            state_d = ST_IDLE;
          end else begin
            gate_d  = route_gate;
            wait_d  = '0;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          // A grant arriving on the final wait cycle takes priority over backoff
          if (grant) begin
            beat_d  = eff_len(len_q);
            wait_d  = '0;
            state_d = ST_XFER;
          end else if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            state_d = ST_BACKOFF;
          end else begin
            wait_d  = wait_q + 4'd1;
          end
        end
        ST_BACKOFF: begin
          wait_d  = '0;
          state_d = ST_REQ;
        end
        ST_XFER: begin
          if (flit_xfer) begin
            if (beat_q == 4'd1) begin
              beat_d  = '0;
              state_d = ST_RELEASE;
            end else begin
              beat_d  = beat_q - 4'd1;
            end
          end
        end
        ST_RELEASE: begin
          gate_d  = GATE_NONE;
          state_d = ST_IDLE;
        end
        default: begin
          gate_d  = GATE_NONE;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      gate_q  <= GATE_NONE;
      wait_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      gate_q  <= gate_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state only (flit_ready follows grant in XFER)
  always_comb begin
    hdr_ready       = rst_n && (state_q == ST_IDLE);
    flit_ready      = (state_q == ST_XFER) && grant;
    handshake_check = hs_of_state(state_q);
    busy            = (state_q != ST_IDLE);
    gate            = gate_q;
    err             = err_q;
    source          = SRC_NONE;
    if (state_q == ST_REQ || state_q == ST_XFER || state_q == ST_RELEASE) begin
      source = SRC_ID;
    end
  end

endmodule
